keypad_scanner: RTL and testbench



---
 rtl/keypad_pkg.sv | 90 +++++++++
 rtl/keypad_scan_timer.sv | 43 ++++
 rtl/keypad_scanner.sv | 140 ++++++++++++++
 tb/tb_keypad_scanner.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner and its consumers.
// Key codes are {row_idx[1:0], col_idx[1:0]} for a standard 1-2-3-A telephone layout.
package keypad_pkg;

    localparam int KEY_W  = 4;
    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int SNAP_W = ROWS * COLS;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DEB_PRESS = 2'd1,
        PRESSED   = 2'd2,
        DEB_REL   = 2'd3
    } kp_state_t;

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_SINGLE = 2'd1,
        CLS_MULTI  = 2'd2
    } kp_class_t;

    typedef struct packed {
        kp_class_t        cls;
        logic [KEY_W-1:0] key;
    } kp_scan_t;

    localparam logic [KEY_W-1:0] KEY_1    = 4'h0;
    localparam logic [KEY_W-1:0] KEY_2    = 4'h1;
    localparam logic [KEY_W-1:0] KEY_3    = 4'h2;
    localparam logic [KEY_W-1:0] KEY_A    = 4'h3;
    localparam logic [KEY_W-1:0] KEY_4    = 4'h4;
    localparam logic [KEY_W-1:0] KEY_5    = 4'h5;
    localparam logic [KEY_W-1:0] KEY_6    = 4'h6;
    localparam logic [KEY_W-1:0] KEY_B    = 4'h7;
    localparam logic [KEY_W-1:0] KEY_7    = 4'h8;
    localparam logic [KEY_W-1:0] KEY_8    = 4'h9;
    localparam logic [KEY_W-1:0] KEY_9    = 4'hA;
    localparam logic [KEY_W-1:0] KEY_C    = 4'hB;
    localparam logic [KEY_W-1:0] KEY_STAR = 4'hC;
    localparam logic [KEY_W-1:0] KEY_0    = 4'hD;
    localparam logic [KEY_W-1:0] KEY_HASH = 4'hE;
    localparam logic [KEY_W-1:0] KEY_D    = 4'hF;

    // Any snapshot with two or more closures may contain ghost keys, so it is only ever MULTI.
    function automatic kp_scan_t classify(input logic [SNAP_W-1:0] snap);
        kp_scan_t    res;
        int unsigned ones;
        res.cls = CLS_NONE;
        res.key = '0;
        ones    = 0;
        for (int unsigned i = 0; i < SNAP_W; i++) begin
            if (snap[i]) begin
                ones    = ones + 1;
                res.key = KEY_W'(i);
            end
        end
        if (ones == 1)
            res.cls = CLS_SINGLE;
        else if (ones > 1)
            res.cls = CLS_MULTI;
        return res;
    endfunction

    function automatic logic [7:0] key_ascii(input logic [KEY_W-1:0] code);
        logic [7:0] c;
        c = "?";
        case (code)
            KEY_1:    c = "1";
            KEY_2:    c = "2";
            KEY_3:    c = "3";
            KEY_A:    c = "A";
            KEY_4:    c = "4";
            KEY_5:    c = "5";
            KEY_6:    c = "6";
            KEY_B:    c = "B";
            KEY_7:    c = "7";
            KEY_8:    c = "8";
            KEY_9:    c = "9";
            KEY_C:    c = "C";
            KEY_STAR: c = "*";
            KEY_0:    c = "0";
            KEY_HASH: c = "#";
            KEY_D:    c = "D";
            default:  c = "?";
        endcase
        return c;
    endfunction

endpackage

// File: rtl/keypad_scan_timer.sv
// Column strobe generator: dwells SCAN_TICKS cycles per column, drives one column low at a time,
// and flags the last tick of each dwell (sample_en) and of the whole 4-column scan (scan_done).
module keypad_scan_timer
    import keypad_pkg::*;
#(
    parameter int SCAN_TICKS = 50000
) (
    input  logic       clock_50Mhz,
    input  logic       reset,
    output logic [1:0] col_idx,
    output logic [3:0] col_out,
    output logic       sample_en,
    output logic       scan_done
);

    localparam int TICK_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_TICKS - 1);

    logic [TICK_W-1:0] tick;
    logic [1:0]        col_next;

    always_comb begin
        col_next = (col_idx == 2'd3) ? 2'd0 : col_idx + 2'd1;
    end

    always_ff @(posedge clock_50Mhz) begin
        if (reset) begin
            tick    <= '0;
            col_idx <= 2'd0;
            col_out <= 4'b1110;
        end else if (tick == TICK_LAST) begin
            tick    <= '0;
            col_idx <= col_next;
            col_out <= ~(4'b0001 << col_next);
        end else begin
            tick    <= tick + TICK_W'(1);
        end
    end

    assign sample_en = (tick == TICK_LAST);
    assign scan_done = sample_en && (col_idx == 2'd3);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad reader: synchronizes rows, builds a 16-bit closure snapshot per scan and debounces
// whole-scan classifications into a single key_valid pulse per clean press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_TICKS     = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic             clock_50Mhz,
    input  logic             reset,
    input  logic [3:0]       row_in,
    output logic [3:0]       col_out,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_held
);

    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS);

    logic [1:0]        col_idx;
    logic              sample_en;
    logic              scan_done;
    logic [3:0]        row_meta;
    logic [3:0]        row_sync;
    logic [SNAP_W-1:0] snapshot;
    logic [SNAP_W-1:0] snap_next;
    kp_scan_t          scan_res;
    kp_state_t         state;
    logic [KEY_W-1:0]  cand;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              is_none;
    logic              is_single;

    keypad_scan_timer #(
        .SCAN_TICKS(SCAN_TICKS)
    ) u_timer (
        .clock_50Mhz(clock_50Mhz),
        .reset      (reset),
        .col_idx    (col_idx),
        .col_out    (col_out),
        .sample_en  (sample_en),
        .scan_done  (scan_done)
    );

    // Rows idle high through the pull-ups, so the synchronizer resets to "no key".
    always_ff @(posedge clock_50Mhz) begin
        if (reset) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
        end
    end

    // The classifier looks at snap_next so the column-3 sample taken on scan_done is included.
    always_comb begin
        snap_next = snapshot;
        if (sample_en) begin
            for (int unsigned r = 0; r < ROWS; r++)
                snap_next[{2'(r), col_idx}] = ~row_sync[r];
        end
    end

    always_ff @(posedge clock_50Mhz) begin
        if (reset)
            snapshot <= '0;
        else
            snapshot <= snap_next;
    end

    always_comb begin
        scan_res  = classify(snap_next);
        is_none   = (scan_res.cls == CLS_NONE);
        is_single = (scan_res.cls == CLS_SINGLE);
        cnt_inc   = (cnt == CNT_LAST) ? cnt : cnt + CNT_W'(1);
    end

    always_ff @(posedge clock_50Mhz) begin
        if (reset) begin
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (scan_done) begin
                case (state)
                    IDLE: begin
                        if (is_single) begin
                            cand  <= scan_res.key;
                            cnt   <= CNT_ONE;
                            state <= DEB_PRESS;
                        end
                    end
                    DEB_PRESS: begin
                        if (is_single && scan_res.key == cand) begin
                            cnt <= cnt_inc;
                            if (cnt_inc == CNT_LAST) begin
                                state     <= PRESSED;
                                key_code  <= cand;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                            end
                        end else if (is_single) begin
                            cand <= scan_res.key;
                            cnt  <= CNT_ONE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    PRESSED: begin
                        if (is_none) begin
                            cnt   <= CNT_ONE;
                            state <= DEB_REL;
                        end
                    end
                    DEB_REL: begin
                        if (is_none) begin
                            cnt <= cnt_inc;
                            if (cnt_inc == CNT_LAST) begin
                                state    <= IDLE;
                                key_held <= 1'b0;
                            end
                        end else begin
                            state <= PRESSED;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_TICKS=4, DEBOUNCE_SCANS=3 (16-cycle scans) and a
// behavioural keypad that pulls a row low when a pressed key sits on the driven column.
module tb_keypad_scanner;

    localparam int ST  = 4;
    localparam int DEB = 3;
    localparam int SCAN_CYC = 4 * ST;

    logic        clock_50Mhz;
    logic        reset;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] keys;

    int n_checks;
    int n_fail;

    keypad_scanner #(
        .SCAN_TICKS    (ST),
        .DEBOUNCE_SCANS(DEB)
    ) dut (
        .clock_50Mhz(clock_50Mhz),
        .reset      (reset),
        .row_in     (row_in),
        .col_out    (col_out),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_held   (key_held)
    );

    initial clock_50Mhz = 1'b0;
    always #5 clock_50Mhz = ~clock_50Mhz;

    always_comb begin
        row_in = '1;
        for (int r = 0; r < 4; r++)
            row_in[r] = ~|(keys[r*4 +: 4] & ~col_out);
    end

    typedef struct {
        logic [15:0] mask;
        logic        v;
        logic        h;
        logic [3:0]  code;
    } vec_t;

    vec_t tbl[$];

    // Reference: runs of identical single-key scans while released, runs of empty scans while held.
    int unsigned m_run;
    int unsigned m_none;
    logic [3:0]  m_key;
    logic        m_held;
    logic [3:0]  m_code;
    logic        m_valid;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_none = 0; m_key = '0; m_held = 1'b0; m_code = '0; m_valid = 1'b0;
    endtask

    task automatic model_scan(input logic [15:0] mask);
        int unsigned n;
        logic [3:0]  k;
        n = $countones(mask);
        k = '0;
        for (int i = 0; i < 16; i++)
            if (mask[i]) k = 4'(i);
        m_valid = 1'b0;
        if (!m_held) begin
            if (n == 1) begin
                if (m_run > 0 && k == m_key) m_run = m_run + 1;
                else begin m_run = 1; m_key = k; end
                if (m_run == DEB) begin
                    m_valid = 1'b1; m_held = 1'b1; m_code = k; m_none = 0;
                end
            end else begin
                m_run = 0;
            end
        end else if (n == 0) begin
            m_none = m_none + 1;
            if (m_none == DEB) begin m_held = 1'b0; m_run = 0; end
        end else begin
            m_none = 0;
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_col"},   int'(col_out),   int'(4'b1110));
        chk({tag, "_code"},  int'(key_code),  0);
        chk({tag, "_valid"}, int'(key_valid), 0);
        chk({tag, "_held"},  int'(key_held),  0);
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        @(posedge clock_50Mhz); #1;
        check_reset_values("rst");
        reset = 1'b0;
        model_reset();
    endtask

    // One full scan with a fixed key set; key_valid must stay low until the scan's own edge.
    task automatic run_scan(input logic [15:0] mask);
        keys = mask;
        for (int i = 1; i <= SCAN_CYC; i++) begin
            @(posedge clock_50Mhz); #1;
            if (i < SCAN_CYC) chk("valid_mid_scan", int'(key_valid), 0);
        end
    endtask

    task automatic check_col_sweep(input int cycles);
        logic [3:0] e;
        for (int k = 1; k <= cycles; k++) begin
            @(posedge clock_50Mhz); #1;
            e = ~(4'b0001 << ((k / ST) % 4));
            chk("col_sweep", int'(col_out), int'(e));
            chk("no_pulse", int'(key_valid), 0);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] m, input logic v, input logic h, input logic [3:0] c);
        vec_t t;
        t.mask = m; t.v = v; t.h = h; t.code = c;
        return t;
    endfunction

    logic [15:0] prev_mask;
    logic [15:0] rmask;
    int unsigned sel;
    int unsigned a;
    int unsigned b;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        keys     = '0;
        reset    = 1'b1;
        model_reset();
        repeat (3) @(posedge clock_50Mhz);
        #1;
        check_reset_values("init");
        reset = 1'b0;

        // Idle sweep: columns rotate every ST cycles and nothing is reported.
        check_col_sweep(13 * SCAN_CYC);
        reset_dut();

        // Press/release, bounce, rollover and two-key ghosting sequences.
        for (int i = 0; i < 3; i++) tbl.push_back(mk(16'h0040, i == 2, i == 2, (i == 2) ? 4'h6 : 4'h0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(16'h0000, 1'b0, i < 2, 4'h6));
        tbl.push_back(mk(16'h0001, 1'b0, 1'b0, 4'h6));
        tbl.push_back(mk(16'h0000, 1'b0, 1'b0, 4'h6));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(16'h0001, i == 2, i == 2, (i == 2) ? 4'h0 : 4'h6));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(16'h0000, 1'b0, i < 2, 4'h0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(16'h0020, i == 2, i == 2, (i == 2) ? 4'h5 : 4'h0));
        for (int i = 0; i < 2; i++) tbl.push_back(mk(16'h0420, 1'b0, 1'b1, 4'h5));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(16'h0000, 1'b0, i < 2, 4'h5));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(16'h0082, 1'b0, 1'b0, 4'h5));

        foreach (tbl[i]) begin
            run_scan(tbl[i].mask);
            chk($sformatf("tbl%0d_valid", i), int'(key_valid), int'(tbl[i].v));
            chk($sformatf("tbl%0d_held", i),  int'(key_held),  int'(tbl[i].h));
            chk($sformatf("tbl%0d_code", i),  int'(key_code),  int'(tbl[i].code));
        end

        // Reset while PRESSED, in the middle of column 1.
        reset_dut();
        for (int i = 0; i < 3; i++) run_scan(16'h0040);
        chk("pre_rst_held", int'(key_held), 1);
        repeat (6) @(posedge clock_50Mhz);
        #1;
        keys = '0;
        reset_dut();
        check_col_sweep(3 * SCAN_CYC);
        chk("post_rst_held", int'(key_held), 0);
        chk("post_rst_code", int'(key_code), 0);

        // Randomized scans against the run-length reference.
        reset_dut();
        prev_mask = '0;
        for (int s = 0; s < 80; s++) begin
            sel = $urandom_range(0, 9);
            if (sel < 2) begin
                rmask = '0;
            end else if (sel < 7) begin
                rmask = prev_mask;
            end else if (sel < 9) begin
                rmask = 16'h0001 << $urandom_range(0, 15);
            end else begin
                a = $urandom_range(0, 15);
                b = (a + $urandom_range(1, 15)) % 16;
                rmask = (16'h0001 << a) | (16'h0001 << b);
            end
            prev_mask = rmask;
            run_scan(rmask);
            model_scan(rmask);
            chk("rnd_valid", int'(key_valid), int'(m_valid));
            chk("rnd_held",  int'(key_held),  int'(m_held));
            chk("rnd_code",  int'(key_code),  int'(m_code));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
